// File: rtl/dmem_io_ctrl.sv
// dmem_io_ctrl: word RAM plus a memory-mapped I/O register file for the MEM stage.
// addr[IO_BIT] selects the I/O region; every read is registered into dataout.
module dmem_io_ctrl #(
    parameter int ADDR_W  = 5,
    parameter int NUM_OUT = 3,
    parameter int NUM_IN  = 2,
    parameter int IO_BIT  = 7
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [31:0]           addr,
    input  logic [31:0]           datain,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic                  re,
    output logic [31:0]           dataout,
    output logic [32*NUM_OUT-1:0] out_ports,
    input  logic [32*NUM_IN-1:0]  in_ports,
    output logic                  irq
);
    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [4:0] W_STATUS = 5'd16;
    localparam logic [4:0] W_MASK   = 5'd17;
    localparam logic [4:0] W_CYCLE  = 5'd18;

    logic [31:0]       mem    [DEPTH];
    logic [31:0]       out_q  [NUM_OUT];
    logic [31:0]       s1_q   [NUM_IN];
    logic [31:0]       s2_q   [NUM_IN];
    logic [31:0]       prev_q [NUM_IN];
    logic [NUM_IN-1:0] status_q, status_d, mask_q, chg;
    logic [31:0]       cycle_q, cycle_d, rdata, dataout_q;
    logic              irq_q;
    logic              is_io, wr_io, rd_status;
    logic [4:0]        io_w;
    logic [ADDR_W-1:0] ram_idx;
    logic              unused_addr;

    function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] en);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = en[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        return r;
    endfunction

    assign is_io       = addr[IO_BIT];
    assign io_w        = addr[6:2];
    assign ram_idx     = addr[ADDR_W+1:2];
    assign wr_io       = we && is_io;
    assign rd_status   = re && is_io && (io_w == W_STATUS);
    assign unused_addr = ^addr;

    // Gating on resetn keeps a reset that overlaps a write from committing it.
    always_ff @(posedge clock) begin
        if (resetn && we && !is_io) mem[ram_idx] <= merge_be(mem[ram_idx], datain, be);
    end

    always_comb begin
        chg = '0;
        for (int k = 0; k < NUM_IN; k++) chg[k] = (s2_q[k] != prev_q[k]);
        // A read clears what it returned, but a change seen at the same edge re-sets the bit.
        status_d = (status_q & ~(rd_status ? status_q : '0)) | chg;
        cycle_d  = (wr_io && io_w == W_CYCLE) ? merge_be(cycle_q, datain, be) : cycle_q + 32'd1;
    end

    always_comb begin
        rdata = '0;
        if (!is_io) begin
            rdata = mem[ram_idx];
        end else begin
            for (int k = 0; k < NUM_OUT; k++) if (io_w == 5'(k)) rdata = out_q[k];
            for (int k = 0; k < NUM_IN; k++) if (io_w == 5'(8 + k)) rdata = s2_q[k];
            case (io_w)
                W_STATUS: rdata = 32'(status_q);
                W_MASK:   rdata = 32'(mask_q);
                W_CYCLE:  rdata = cycle_q;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
            for (int k = 0; k < NUM_IN; k++) begin
                s1_q[k]   <= '0;
                s2_q[k]   <= '0;
                prev_q[k] <= '0;
            end
            status_q  <= '0;
            mask_q    <= '0;
            cycle_q   <= '0;
            dataout_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                s1_q[k]   <= in_ports[32*k +: 32];
                s2_q[k]   <= s1_q[k];
                prev_q[k] <= s2_q[k];
            end
            for (int k = 0; k < NUM_OUT; k++)
                if (wr_io && io_w == 5'(k)) out_q[k] <= merge_be(out_q[k], datain, be);
            if (wr_io && io_w == W_MASK && be[0]) mask_q <= datain[NUM_IN-1:0];
            status_q <= status_d;
            cycle_q  <= cycle_d;
            irq_q    <= |(status_q & mask_q);
            if (re) dataout_q <= rdata;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_OUT; g++) begin : g_out
            assign out_ports[32*g +: 32] = out_q[g];
        end
    endgenerate

    assign dataout = dataout_q;
    assign irq     = irq_q;
endmodule
